// File: rtl/axi4l_log_pkg.sv
// Shared types and frame constants for the AXI4-Lite logger byte serializer.
// Build option: AXI4L_LOG_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte.
package axi4l_log_pkg;

    localparam int LOG_ADDR_W = 32;
    localparam int LOG_DATA_W = 32;

    typedef struct packed {
        logic                  rnw;
        logic [LOG_ADDR_W-1:0] addr;
        logic [LOG_DATA_W-1:0] data;
    } log_entry_t;

`ifdef AXI4L_LOG_SERIALIZER_CHECKSUM_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/log_frame_mux.sv
// Selects one frame byte (header, address, data, optional checksum) from a log entry.
// Build option: AXI4L_LOG_SERIALIZER_CHECKSUM_EN enables byte 9 = XOR of bytes 0..8.
module log_frame_mux
    import axi4l_log_pkg::*;
#(
    parameter logic [7:0] HDR_READ  = 8'h52,
    parameter logic [7:0] HDR_WRITE = 8'h57
) (
    input  log_entry_t entry,
    input  logic [3:0] idx,
    output logic [7:0] tx_byte
);

    logic [7:0] hdr;
    assign hdr = entry.rnw ? HDR_READ : HDR_WRITE;

    always_comb begin
        tx_byte = 8'h00;
        case (idx)
            4'd0: tx_byte = hdr;
            4'd1: tx_byte = entry.addr[31:24];
            4'd2: tx_byte = entry.addr[23:16];
            4'd3: tx_byte = entry.addr[15:8];
            4'd4: tx_byte = entry.addr[7:0];
            4'd5: tx_byte = entry.data[31:24];
            4'd6: tx_byte = entry.data[23:16];
            4'd7: tx_byte = entry.data[15:8];
            4'd8: tx_byte = entry.data[7:0];
`ifdef AXI4L_LOG_SERIALIZER_CHECKSUM_EN
            4'd9: tx_byte = hdr ^ entry.addr[31:24] ^ entry.addr[23:16] ^ entry.addr[15:8]
                          ^ entry.addr[7:0] ^ entry.data[31:24] ^ entry.data[23:16]
                          ^ entry.data[15:8] ^ entry.data[7:0];
`endif
            default: tx_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/axi4l_log_serializer.sv
// Pops logger FIFO entries and streams each as a fixed-length byte frame over valid/ready.
// Build option: AXI4L_LOG_SERIALIZER_CHECKSUM_EN adds a trailing XOR checksum byte.
module axi4l_log_serializer
    import axi4l_log_pkg::*;
#(
    parameter logic [7:0] HDR_READ  = 8'h52,
    parameter logic [7:0] HDR_WRITE = 8'h57,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 empty,
    output logic                 r_req,
    input  logic                 r_rnw,
    input  logic [31:0]          r_addr,
    input  logic [31:0]          r_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    state_t     state;
    logic [3:0] idx;
    log_entry_t entry;

    log_entry_t pop_entry;
    log_entry_t mux_entry;
    logic [3:0] mux_idx;
    logic [7:0] next_byte;
    logic       hs;

    // Gated by nrst so nothing is popped (and lost) while reset is held.
    assign r_req     = nrst & en & ~empty & (state == IDLE);
    assign pop_entry = {r_rnw, r_addr, r_data};
    assign hs        = tx_valid & tx_ready;

    // In IDLE the mux looks at the FIFO head so byte 0 is registered on the pop edge.
    assign mux_entry = (state == IDLE) ? pop_entry : entry;
    assign mux_idx   = (state == IDLE) ? 4'd0 : idx + 4'd1;

    log_frame_mux #(
        .HDR_READ (HDR_READ),
        .HDR_WRITE(HDR_WRITE)
    ) u_mux (
        .entry  (mux_entry),
        .idx    (mux_idx),
        .tx_byte(next_byte)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            entry     <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (r_req) begin
                        entry    <= pop_entry;
                        idx      <= 4'd0;
                        tx_data  <= next_byte;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (idx == LAST_IDX) begin
                            tx_valid  <= 1'b0;
                            busy      <= 1'b0;
                            frame_cnt <= frame_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            state     <= IDLE;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_log_serializer.sv
// Directed bench: FWFT FIFO model feeds entries, a scoreboard checks every streamed byte.
module tb_axi4l_log_serializer;
    import axi4l_log_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        empty = 1'b1;
    logic        r_rnw = 1'b0;
    logic [31:0] r_addr = '0;
    logic [31:0] r_data = '0;
    logic        tx_ready = 1'b0;
    logic        r_req;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] frame_cnt;

    axi4l_log_serializer #(
        .HDR_READ (8'h52),
        .HDR_WRITE(8'h57),
        .CNT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .empty    (empty),
        .r_req    (r_req),
        .r_rnw    (r_rnw),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         pop_cnt = 0;
    int         hs_cnt = 0;
    int         cyc = 0;
    int         pop_edge[$];
    int         fc_edge[$];
    logic [64:0] ent_q[$];
    logic [7:0] exp_q[$];
    logic       req_s;
    logic [15:0] fc_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        empty = (ent_q.size() == 0);
        if (!empty) {r_rnw, r_addr, r_data} = ent_q[0];
    endfunction

    task automatic push_entry(input logic rnw, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b[9];
        logic [7:0] x;
        b = '{(rnw ? 8'h52 : 8'h57), a[31:24], a[23:16], a[15:8], a[7:0],
              d[31:24], d[23:16], d[15:8], d[7:0]};
        x = 8'h00;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(b[i]);
            x = x ^ b[i];
        end
`ifdef AXI4L_LOG_SERIALIZER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        ent_q.push_back({rnw, a, d});
        refresh();
    endtask

    task automatic wait_fc(input string tag, input int target);
        for (int i = 0; i < 80 && frame_cnt !== 16'(target); i++) @(negedge clk);
        chk(tag, frame_cnt, target);
    endtask

    // FIFO model and byte monitor; r_req/handshakes sampled mid-cycle, pops applied after the edge.
    always begin
        @(negedge clk);
        req_s = r_req;
        fc_s  = frame_cnt;
        if (nrst && tx_valid && tx_ready) begin
            hs_cnt++;
            chk("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("tx_byte", tx_data, exp_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        #1;
        if (req_s === 1'b1) begin
            pop_cnt++;
            pop_edge.push_back(cyc);
            if (ent_q.size() > 0) void'(ent_q.pop_front());
            refresh();
        end
        if (frame_cnt !== fc_s) fc_edge.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, base, stalled, d1, d2;

        // Reset with an entry waiting and en=1: nothing may pop.
        nrst = 1'b0;
        en   = 1'b1;
        push_entry(1'b0, 32'h4000_0010, 32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_r_req", r_req, 0);

        // Write frame, free-flowing sink.
        @(posedge clk); #1;
        pop_edge.delete();
        fc_edge.delete();
        pop_cnt  = 0;
        tx_ready = 1'b1;
        nrst     = 1'b1;
        wait_fc("wr_frame_cnt", 1);
        chk("wr_pops", pop_cnt, 1);
        chk("wr_bytes_left", exp_q.size(), 0);
        d1 = (pop_edge.size() > 0 && fc_edge.size() > 0) ? fc_edge[0] - pop_edge[0] : -1;
        chk("wr_latency", d1, FRAME_LEN);

        // Read frame with a 3-cycle stall while byte 2 is presented.
        @(posedge clk); #1;
        base    = hs_cnt;
        stalled = 0;
        push_entry(1'b1, 32'h0000_0004, 32'h1234_5678);
        for (int i = 0; i < 60 && frame_cnt !== 16'd2; i++) begin
            @(posedge clk); #1;
            if (hs_cnt - base == 2 && stalled < 3) begin
                tx_ready = 1'b0;
                stalled++;
                @(negedge clk);
                chk("stall_valid", tx_valid, 1);
                chk("stall_byte", tx_data, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
            end else begin
                tx_ready = 1'b1;
            end
        end
        tx_ready = 1'b1;
        chk("rd_stalls", stalled, 3);
        wait_fc("rd_frame_cnt", 2);
        chk("rd_bytes_left", exp_q.size(), 0);

        // Two queued entries back to back.
        @(posedge clk); #1;
        pop_edge.delete();
        fc_edge.delete();
        push_entry(1'b0, 32'hA5A5_0000, 32'h0000_00FF);
        push_entry(1'b1, 32'hFFFF_FFFC, 32'h8000_0001);
        wait_fc("b2b_frame_cnt", 4);
        chk("b2b_pops", pop_edge.size(), 2);
        d1 = (pop_edge.size() >= 2) ? pop_edge[1] - pop_edge[0] : -1;
        d2 = (pop_edge.size() >= 1 && fc_edge.size() >= 2) ? fc_edge[1] - pop_edge[0] : -1;
        chk("b2b_pop_gap", d1, FRAME_LEN + 1);
        chk("b2b_total", d2, 2 * FRAME_LEN + 1);

        // en=0 with data available: no pop.
        @(posedge clk); #1;
        en = 1'b0;
        p0 = pop_cnt;
        push_entry(1'b1, 32'h0000_1000, 32'hCAFE_F00D);
        repeat (20) @(posedge clk);
        #1;
        chk("en0_no_pop", pop_cnt - p0, 0);
        chk("en0_tx_valid", tx_valid, 0);

        // en dropped at byte 4: frame completes, the next entry stays queued.
        push_entry(1'b0, 32'h1111_2222, 32'h3333_4444);
        base = hs_cnt;
        en   = 1'b1;
        for (int i = 0; i < 40 && hs_cnt - base < 4; i++) begin
            @(posedge clk); #1;
        end
        en = 1'b0;
        chk("en_drop_byte4", hs_cnt - base, 4);
        wait_fc("en_drop_frame_cnt", 5);
        repeat (15) @(posedge clk);
        #1;
        chk("en_drop_pops", pop_cnt - p0, 1);
        chk("en_drop_queued", ent_q.size(), 1);
        chk("en_drop_busy", busy, 0);

        // Reset while byte 5 is presented; the popped entry is abandoned.
        base = hs_cnt;
        en   = 1'b1;
        for (int i = 0; i < 40 && hs_cnt - base < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_byte5", hs_cnt - base, 5);
        nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_tx_valid", tx_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        p0   = pop_cnt;
        push_entry(1'b1, 32'h0BAD_0C0D, 32'h7654_3210);
        wait_fc("post_rst_frame_cnt", 1);
        chk("post_rst_pops", pop_cnt - p0, 1);
        chk("post_rst_bytes_left", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
